// File: rtl/serial_deserializer.sv
// Multi-lane serial-to-parallel deserializer with bit framing and a valid/ready holding register.
// A completed word is in Q at the edge that takes its last bit; it is dropped and flagged in OVF if Q is still held.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic [LANES-1:0]           D,
  input  logic                       FRAME,
  input  logic                       READY,
  input  logic                       OVF_CLR,
  output logic [WIDTH*LANES-1:0]     Q,
  output logic                       VALID,
  output logic                       OVF,
  output logic [$clog2(WIDTH)-1:0]   BITCNT
);

  localparam int CW = $clog2(WIDTH);

  logic [LANES-1:0][WIDTH-1:0] sr;
  logic [LANES-1:0][WIDTH-1:0] sr_nxt;
  logic                        last_bit;
  logic                        complete;
  logic                        hold_free;

  always_comb begin
    sr_nxt = sr;
    for (int i = 0; i < LANES; i++) begin
      if (LSB_FIRST)
        sr_nxt[i] = {D[i], sr[i][WIDTH-1:1]};
      else
        sr_nxt[i] = {sr[i][WIDTH-2:0], D[i]};
    end
  end

  // FRAME restarts the word, so it can never coincide with a completion (WIDTH >= 2).
  assign last_bit  = (BITCNT == CW'(WIDTH - 1));
  assign complete  = CE && !FRAME && last_bit;
  assign hold_free = !VALID || READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr     <= '0;
      BITCNT <= '0;
      Q      <= '0;
      VALID  <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      if (CE) begin
        sr <= sr_nxt;
        if (FRAME)
          BITCNT <= CW'(1);
        else if (last_bit)
          BITCNT <= '0;
        else
          BITCNT <= BITCNT + CW'(1);
      end

      if (complete && hold_free) begin
        Q     <= sr_nxt;
        VALID <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end

      // A drop on the same edge as a clear leaves the flag set.
      if (complete && !hold_free)
        OVF <= 1'b1;
      else if (OVF_CLR)
        OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized and directed bench for serial_deserializer with a queue-based scoreboard.
module tb_serial_deserializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  // Instance a: WIDTH=8, LANES=1, MSB first
  logic       ce_a = 1'b0, fr_a = 1'b0, rdy_a = 1'b0, clr_a = 1'b0;
  logic [0:0] d_a = '0;
  logic [7:0] q_a;
  logic       vld_a, ovf_a;
  logic [2:0] cnt_a;

  // Instance b: WIDTH=4, LANES=2, LSB first
  logic       ce_b = 1'b0, fr_b = 1'b0, rdy_b = 1'b1, clr_b = 1'b0;
  logic [1:0] d_b = '0;
  logic [7:0] q_b;
  logic       vld_b, ovf_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  // Reference state for instance a
  bit         bits[$];
  logic [7:0] m_q;
  bit         m_v, m_o;

  always #5 CLK = ~CLK;

  serial_deserializer #(.WIDTH(8), .LANES(1), .LSB_FIRST(1'b0)) dut_a (
    .CLK(CLK), .RST(RST), .CE(ce_a), .D(d_a), .FRAME(fr_a), .READY(rdy_a),
    .OVF_CLR(clr_a), .Q(q_a), .VALID(vld_a), .OVF(ovf_a), .BITCNT(cnt_a)
  );

  serial_deserializer #(.WIDTH(4), .LANES(2), .LSB_FIRST(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .CE(ce_b), .D(d_b), .FRAME(fr_b), .READY(rdy_b),
    .OVF_CLR(clr_b), .Q(q_b), .VALID(vld_b), .OVF(ovf_b), .BITCNT(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    m_q = '0;
    m_v = 1'b0;
    m_o = 1'b0;
  endtask

  // One edge of the reference behaviour, written over a list of received bits
  task automatic model_edge(input bit ce, input bit fr, input bit d, input bit rdy, input bit clr);
    bit         done = 1'b0;
    bit         free;
    logic [7:0] w = '0;
    free = !m_v || rdy;
    if (ce) begin
      if (fr) bits.delete();
      bits.push_back(d);
      if (bits.size() == 8) begin
        foreach (bits[k]) w = w | (8'(bits[k]) << (7 - k));
        bits.delete();
        done = 1'b1;
      end
    end
    if (done && free) begin
      m_q = w;
      m_v = 1'b1;
      exp_a.push_back(w);
    end else if (m_v && rdy) begin
      m_v = 1'b0;
    end
    if (done && !free) m_o = 1'b1;
    else if (clr) m_o = 1'b0;
  endtask

  task automatic check_state();
    chk("q_a", 32'(q_a), 32'(m_q));
    chk("valid_a", 32'(vld_a), 32'(m_v));
    chk("ovf_a", 32'(ovf_a), 32'(m_o));
    chk("bitcnt_a", 32'(cnt_a), 32'(bits.size()));
  endtask

  task automatic step(input bit ce, input bit fr, input bit d, input bit rdy, input bit clr);
    ce_a  = ce;
    fr_a  = fr;
    d_a   = d;
    rdy_a = rdy;
    clr_a = clr;
    @(posedge CLK);
    model_edge(ce, fr, d, rdy, clr);
    #1;
    check_state();
  endtask

  task automatic send_word(input logic [7:0] w, input bit fr, input bit rdy, input bit rdy_last, input bit clr_last);
    for (int k = 0; k < 8; k++)
      step(1'b1, fr && (k == 0), w[7-k], (k == 7) ? rdy_last : rdy, clr_last && (k == 7));
  endtask

  task automatic stepb(input logic [1:0] d);
    ce_b = 1'b1;
    d_b  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_b(input logic [3:0] w0, input logic [3:0] w1);
    exp_b.push_back({w1, w0});
    for (int k = 0; k < 4; k++) stepb({w1[k], w0[k]});
  endtask

  // Monitor a: a word is newly presented when VALID is high after an edge
  // at which the holding register was empty or was being consumed.
  initial begin : mon_a
    bit pv, pa;
    logic [7:0] e;
    forever begin
      @(posedge CLK);
      pv = vld_a;
      pa = vld_a && rdy_a;
      #2;
      if (!RST && vld_a && (!pv || pa)) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_a unexpected got %0h expected none", q_a);
        end else begin
          e = exp_a.pop_front();
          chk("word_a", 32'(q_a), 32'(e));
        end
      end
    end
  end

  // Monitor b: READY is always high, so each VALID cycle is one word
  initial begin : mon_b
    logic [7:0] e;
    forever begin
      @(posedge CLK);
      #2;
      if (!RST && vld_b) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_b unexpected got %0h expected none", q_b);
        end else begin
          e = exp_b.pop_front();
          chk("word_b", 32'(q_b), 32'(e));
          chk("ovf_b", 32'(ovf_b), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    #12;
    chk("rst_q", 32'(q_a), 32'd0);
    chk("rst_valid", 32'(vld_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_bitcnt", 32'(cnt_a), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // MSB-first capture
    send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_direct", 32'(q_a), 32'hA5);
    chk("a5_bitcnt", 32'(cnt_a), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // CE gaps then FRAME realignment
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_bitcnt", 32'(cnt_a), 32'd3);
    send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("frame_direct", 32'(q_a), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow, with a clear colliding with a third drop
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_q", 32'(q_a), 32'h11);
    chk("ovf_set", 32'(ovf_a), 32'd1);
    send_word(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(ovf_a), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf_a), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Consume and complete on the same edge
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("swap_q", 32'(q_a), 32'h22);
    chk("swap_valid", 32'(vld_a), 32'd1);
    chk("swap_ovf", 32'(ovf_a), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("swap_consumed", 32'(vld_a), 32'd0);

    // Back-to-back words with READY high are never dropped
    for (int i = 0; i < 4; i++) send_word(8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Async reset mid-word with VALID high
    send_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_q", 32'(q_a), 32'd0);
    chk("arst_valid", 32'(vld_a), 32'd0);
    chk("arst_ovf", 32'(ovf_a), 32'd0);
    chk("arst_bitcnt", 32'(cnt_a), 32'd0);
    model_reset();
    ce_a = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    send_word(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_ff", 32'(q_a), 32'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first two-lane instance
    send_b(4'h1, 4'h8);
    for (int i = 0; i < 30; i++) send_b(4'($urandom), 4'($urandom));
    ce_b = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
